// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op encodings, FSM states and defaults for mult_div_unit
package mdu_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

endpackage

// File: rtl/mdu_addsub.sv
// rtl/mdu_addsub.sv - W+1 bit adder/subtractor shared by multiply and divide steps
module mdu_addsub #(
  parameter int W = 32
) (
  input  logic [W:0] x,
  input  logic [W:0] y,
  input  logic       sub,
  output logic [W:0] res,
  output logic       cout
);

  logic [W+1:0] sum;

  // x + y, or x - y as x + ~y + 1; cout=1 on subtract means no borrow
  always_comb begin
    sum  = {1'b0, x} + {1'b0, (sub ? ~y : y)} + {{(W+1){1'b0}}, sub};
    res  = sum[W:0];
    cout = sum[W+1];
  end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative HI/LO multiply/divide unit (optional MDU_DIV_ZERO_TRAP_EN)
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;
  logic               fin_q, fin_d;     // result written, done pulse due next edge
  logic               trap_q, trap_d;   // divide-by-zero short cut taken
  logic               div_q, div_d;
  logic               sa_q, sa_d;       // sign of a (signed ops only)
  logic               sb_q, sb_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   ph_q, ph_d;       // product high half / partial remainder
  logic [WIDTH-1:0]   pl_q, pl_d;       // multiplier bits / quotient bits
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // |a| for multiply, |b| for divide

  logic               accept;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     as_x, as_y, as_res;
  logic               as_cout;
  logic [2*WIDTH-1:0] prod;

  assign accept = start & ~busy_q;
  assign mag_a  = (~op[0] & a[WIDTH-1]) ? -a : a;
  assign mag_b  = (~op[0] & b[WIDTH-1]) ? -b : b;
  assign prod   = {ph_q, pl_q};

  // divide: shifted remainder minus divisor; multiply: high half plus multiplicand when the low bit is set
  assign as_x = div_q ? {ph_q, pl_q[WIDTH-1]} : {1'b0, ph_q};
  assign as_y = {1'b0, ((div_q | pl_q[0]) ? opnd_q : {WIDTH{1'b0}})};

  mdu_addsub #(.W(WIDTH)) u_addsub (
    .x    (as_x),
    .y    (as_y),
    .sub  (div_q),
    .res  (as_res),
    .cout (as_cout)
  );

  // FSM, iteration datapath and HI/LO update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    fin_d   = fin_q;
    trap_d  = trap_q;
    div_d   = div_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    ph_d    = ph_q;
    pl_d    = pl_q;
    opnd_d  = opnd_q;
    case (state_q)
      ST_IDLE: begin
        if (fin_q) begin
          fin_d  = 1'b0;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else if (accept) begin
          case (op)
            MDU_MTHI: hi_d = a;
            MDU_MTLO: lo_d = a;
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
              busy_d  = 1'b1;
              cnt_d   = '0;
              div_d   = op[1];
              sa_d    = ~op[0] & a[WIDTH-1];
              sb_d    = ~op[0] & b[WIDTH-1];
              opnd_d  = op[1] ? mag_b : mag_a;
              pl_d    = op[1] ? mag_a : mag_b;
              ph_d    = '0;
              trap_d  = 1'b0;
              state_d = ST_RUN;
`ifdef MDU_DIV_ZERO_TRAP_EN
              if (op[1] && (b == '0)) begin
                trap_d  = 1'b1;
                state_d = ST_FIX;
              end
`endif
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (div_q) begin
          ph_d = as_cout ? as_res[WIDTH-1:0] : as_x[WIDTH-1:0];
          pl_d = {pl_q[WIDTH-2:0], as_cout};
        end else begin
          ph_d = as_res[WIDTH:1];
          pl_d = {as_res[0], pl_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
        else                            cnt_d   = cnt_q + 1'b1;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        if (trap_q) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          dz_d   = 1'b1;
        end else begin
          fin_d = 1'b1;
          if (div_q) begin
            lo_d = (sa_q ^ sb_q) ? -pl_q : pl_q;
            hi_d = sa_q ? -ph_q : ph_q;
          end else begin
            {hi_d, lo_d} = (sa_q ^ sb_q) ? -prod : prod;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state registers with asynchronous abort
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      fin_q   <= 1'b0;
      trap_q  <= 1'b0;
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      ph_q    <= '0;
      pl_q    <= '0;
      opnd_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      fin_q   <= fin_d;
      trap_q  <= trap_d;
      div_q   <= div_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ph_q    <= ph_d;
      pl_q    <= pl_d;
      opnd_q  <= opnd_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  typedef struct packed {
    logic         dz;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic is_md(input logic [2:0] o);
    return (o == MDU_MULT) || (o == MDU_MULTU) || (o == MDU_DIV) || (o == MDU_DIVU);
  endfunction

  // reference: plain arithmetic plus the sign rules for HI/LO
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic [W-1:0] ch, input logic [W-1:0] cl);
    exp_t        e;
    longint      sp;
    logic [63:0] up;
    logic [W-1:0] ma, mb, q, r;
    logic        na, nb;
    e.dz = 1'b0; e.hi = ch; e.lo = cl;
    case (o)
      MDU_MULT: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        {e.hi, e.lo} = sp;
      end
      MDU_MULTU: begin
        up = {32'b0, x} * {32'b0, y};
        {e.hi, e.lo} = up;
      end
      MDU_DIV, MDU_DIVU: begin
        na = (o == MDU_DIV) && x[W-1];
        nb = (o == MDU_DIV) && y[W-1];
        ma = na ? -x : x;
        mb = nb ? -y : y;
        if (mb == '0) begin
`ifdef MDU_DIV_ZERO_TRAP_EN
          e.dz = 1'b1;
          return e;
`else
          q = '1;
          r = ma;
`endif
        end else begin
          q = ma / mb;
          r = ma % mb;
        end
        e.lo = (na ^ nb) ? -q : q;
        e.hi = na ? -r : r;
      end
      MDU_MTHI: e.hi = x;
      MDU_MTLO: e.lo = x;
      default: ;
    endcase
    return e;
  endfunction

  function automatic int exp_busy(input logic [2:0] o, input logic [W-1:0] y);
    if (!is_md(o)) return 0;
`ifdef MDU_DIV_ZERO_TRAP_EN
    if (o[1] && y == '0) return 1;
`endif
    return 34;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done=1 hi=%h lo=%h expected no done", hi, lo);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({div_zero, hi, lo} !== e) begin
          errors++;
          $display("FAIL result: got dz=%0b hi=%h lo=%h expected dz=%0b hi=%h lo=%h",
                   div_zero, hi, lo, e.dz, e.hi, e.lo);
        end
      end
    end
  end

  // present one request for one clock; accepted requests update the model
  task automatic drive(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit acc);
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 3'b111; a = $urandom; b = $urandom;
    if (acc) begin
      e = model(o, x, y, m_hi, m_lo);
      if (is_md(o)) exp_q.push_back(e);
      m_hi = e.hi;
      m_lo = e.lo;
    end
  endtask

  task automatic wait_idle(input string name, input int expect_busy);
    int n = 0;
    int guard = 0;
    while (busy && guard < 200) begin
      n++;
      guard++;
      @(negedge clk);
    end
    if (expect_busy >= 0) check(name, 64'(n), 64'(expect_busy));
    else if (busy) check(name, 64'(busy), 64'd0);
  endtask

  task automatic run(input string name, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    drive(o, x, y, 1'b1);
    wait_idle(name, exp_busy(o, y));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0;
    #1;
    check("reset_outputs", {29'b0, busy, done, div_zero, hi}, 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run("multu_max_busy", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run("mult_neg_busy", MDU_MULT, 32'hFFFF_FFFD, 32'd7);
    check("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run("divu_busy", MDU_DIVU, 32'd100, 32'd7);
    check("divu_100_7", {hi, lo}, {32'd2, 32'd14});
    run("div_neg_busy", MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run("div_ovf_busy", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf", {hi, lo}, {32'd0, 32'h8000_0000});

    // start while busy is dropped entirely
    drive(MDU_MULTU, 32'd2, 32'd3, 1'b1);
    repeat (3) @(negedge clk);
    drive(MDU_MTHI, 32'h1234, 32'd0, 1'b0);
    wait_idle("ignored_mthi_busy", -1);
    check("ignored_mthi", {hi, lo}, {32'd0, 32'd6});

    run("mthi_busy", MDU_MTHI, 32'h1234, 32'd0);
    check("mthi", 64'(hi), 64'h1234);
    run("mtlo_busy", MDU_MTLO, 32'hABCD, 32'd0);
    check("mtlo", {hi, lo}, {32'h1234, 32'hABCD});

    run("divu_zero_busy", MDU_DIVU, 32'd5, 32'd0);
`ifdef MDU_DIV_ZERO_TRAP_EN
    check("divu_zero", {hi, lo}, {32'h1234, 32'hABCD});
`else
    check("divu_zero", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
`endif

    // asynchronous abort in the middle of RUN
    drive(MDU_MULTU, 32'd7, 32'd9, 1'b1);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_state", {31'b0, busy, hi}, 64'd0);
    check("abort_lo_done", {31'b0, done, lo}, 64'd0);
    exp_q.delete();
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_busy", 64'(busy), 64'd0);
    run("after_abort_busy", MDU_MULTU, 32'd4, 32'd5);
    check("after_abort", 64'(lo), 64'd20);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      if (i < 30) ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 20));
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 300));
      run("rand_busy", ro, ra, rb);
    end

    repeat (3) @(negedge clk);
    check("pending_done", 64'(exp_q.size()), 64'd0);
    check("final_hilo", {hi, lo}, {m_hi, m_lo});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
